// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multicore memory arbiter: FSM encoding,
// default sizing and a small index helper.
package mem_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t RESP  = 2'd2;

  // Next core index after idx, wrapping at n (n may be any value 2..8).
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    logic [3:0] s;
    s = {1'b0, idx} + 4'd1;
    return (s >= 4'(n)) ? 3'd0 : s[2:0];
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational rotating-priority picker: the first eligible request at or
// after rr_ptr (wrapping) wins. Masked bits are never eligible.
module mem_arb_rr_pick import mem_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [2:0]       rr_ptr,
  output logic             valid,
  output logic [2:0]       index
);

  // Padded to 8 entries so a 3-bit index is always in range.
  logic [7:0]       elig_pad;
  logic [N_REQ-1:0] hit;
  logic [2:0]       pos [N_REQ];

  assign elig_pad = 8'(req & ~mask);

  // Slot gi of the rotated view holds core (rr_ptr + gi) mod N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [3:0] sum;
      assign sum     = {1'b0, rr_ptr} + 4'(gi);
      assign pos[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
      assign hit[gi] = elig_pad[pos[gi]];
    end
  endgenerate

  // Lowest rotated slot wins; scan from the far end so it is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid = 1'b1;
        index = pos[k];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ cores.
// One access at a time: IDLE -> ISSUE (memory strobe) -> RESP (ack/data).
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  state_t           state_reg;
  logic [2:0]       grant_id_reg;
  logic [2:0]       rr_ptr_reg;
  logic [DW-1:0]    rdata_reg;
  logic             wr_reg;

  logic             in_issue;
  logic             in_resp;
  logic [2:0]       rr_after;
  logic [7:0]       we_pad;
  logic [N_REQ-1:0] owner_mask;
  logic             pick_valid;
  logic [2:0]       pick_idx;

  assign in_issue = (state_reg == ISSUE);
  assign in_resp  = (state_reg == RESP);
  assign rr_after = wrap_inc(grant_id_reg, N_REQ);
  assign we_pad   = 8'(we);

  // Owner one-hot doubles as the RESP-cycle mask and the ack decode.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_owner
      assign owner_mask[gi] = (grant_id_reg == 3'(gi));
      assign ack[gi]        = in_resp && owner_mask[gi];
    end
  endgenerate

  // In RESP the owner still holds req, so it is masked and the search
  // already starts from the pointer value being committed this cycle.
  mem_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .mask   (in_resp ? owner_mask : '0),
    .rr_ptr (in_resp ? rr_after : rr_ptr_reg),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  assign grant_id  = grant_id_reg;
  assign busy      = (state_reg != IDLE);
  assign mem_en    = in_issue;
  assign mem_we    = in_issue && we_pad[grant_id_reg];
  assign mem_addr  = in_issue ? addr[int'(grant_id_reg)*AW +: AW]  : '0;
  assign mem_wdata = in_issue ? wdata[int'(grant_id_reg)*DW +: DW] : '0;
  // Read data is visible together with the read ack, then held.
  assign rdata     = (in_resp && !wr_reg) ? mem_rdata : rdata_reg;

  // Access sequencing and winner latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      wr_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_id_reg <= pick_idx;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          wr_reg    <= mem_we;
          state_reg <= RESP;
        end
        RESP: begin
          if (pick_valid) begin
            grant_id_reg <= pick_idx;
            state_reg    <= ISSUE;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Round-robin pointer advance and read-data capture at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      rdata_reg  <= '0;
    end else if (in_resp) begin
      rr_ptr_reg <= rr_after;
      if (!wr_reg) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand sequences for
// contention / wrap / async reset / idle, then random traffic vs a model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N_RAND = 1500;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we  = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [2:0]      grant_id;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 13) return 16'h0005;
    return 16'((i * 263) ^ 16'h5A3C);
  endfunction

  // Memory array behind the arbiter: registered read, write on strobe.
  logic       mem_load = 1'b0;
  logic [15:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; mem_load = 1'b1;
    tick(); tick();
    mem_load = 1'b0; rst = 1'b0;
  endtask

  task automatic set_core(input int k, input logic w, input logic [7:0] a, input logic [15:0] d);
    we[k] = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic rand_fields(input int k);
    set_core(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
  endtask

  typedef struct {
    int          core;
    logic        wr;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  // Reference model: accesses are scheduled as whole transactions.
  typedef struct {
    bit          valid;
    int          g;      // cycle in which the access was won
    int          core;
    bit          wr;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] rd;
  } acc_t;
  acc_t        cur, nw;
  logic [15:0] ref_mem [256];
  int          next_arb, last_w, start, kk;
  logic [15:0] rd_exp;
  logic [N-1:0] elig;
  bit          exp_en, exp_ackc, granted;
  bit          hold_f [N];
  bit          drop_f [N];

  initial begin
    tbl[0] = '{2, 1'b0, 8'h0D, 16'h0000, 16'h0005};
    tbl[1] = '{0, 1'b1, 8'h0F, 16'h000C, 16'h0005};
    tbl[2] = '{0, 1'b0, 8'h0F, 16'h0000, 16'h000C};
    tbl[3] = '{3, 1'b1, 8'hFF, 16'hBEEF, 16'h000C};
    tbl[4] = '{1, 1'b0, 8'hFF, 16'h0000, 16'hBEEF};
    tbl[5] = '{3, 1'b0, 8'h00, 16'h0000, 16'h5A3C};
    tbl[6] = '{1, 1'b1, 8'h00, 16'h1234, 16'h5A3C};
    tbl[7] = '{2, 1'b0, 8'h00, 16'h0000, 16'h1234};

    // Reset state
    mem_load = 1'b1;
    tick(); tick();
    mem_load = 1'b0;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_en", 64'(mem_en), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_maddr", 64'(mem_addr), 64'(0));
    check("rst_mwdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;

    // Directed single accesses from IDLE
    for (int i = 0; i < 8; i++) begin
      set_core(tbl[i].core, tbl[i].wr, tbl[i].a, tbl[i].wd);
      req[tbl[i].core] = 1'b1;
      tick();
      check("tbl_en", 64'(mem_en), 64'(1));
      check("tbl_we", 64'(mem_we), 64'(tbl[i].wr));
      check("tbl_maddr", 64'(mem_addr), 64'(tbl[i].a));
      check("tbl_grant", 64'(grant_id), 64'(tbl[i].core));
      check("tbl_ack_early", 64'(ack), 64'(0));
      if (tbl[i].wr) check("tbl_mwdata", 64'(mem_wdata), 64'(tbl[i].wd));
      tick();
      check("tbl_ack", 64'(ack), 64'(1) << tbl[i].core);
      check("tbl_rdata", 64'(rdata), 64'(tbl[i].exp_rd));
      check("tbl_en_resp", 64'(mem_en), 64'(0));
      req[tbl[i].core] = 1'b0;
      tick();
      check("tbl_busy_after", 64'(busy), 64'(0));
      check("tbl_rdata_hold", 64'(rdata), 64'(tbl[i].exp_rd));
      $display("txn table %0d: core=%0d wr=%0d addr=%02h rdata=%04h", i, tbl[i].core, tbl[i].wr, tbl[i].a, rdata);
    end

    // Full contention: all cores request continuously from reset
    do_reset();
    for (int k = 0; k < N; k++) set_core(k, 1'b0, 8'(8'h20 + k), 16'h0);
    req = '1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j % 2 == 0) begin
        check("cont_ack", 64'(ack), 64'(1) << (((j - 2) / 2) % N));
        $display("txn contention: ack=%b", ack);
      end else begin
        check("cont_ack_gap", 64'(ack), 64'(0));
        check("cont_grant", 64'(grant_id), 64'(((j - 1) / 2) % N));
      end
      check("cont_en", 64'(mem_en), 64'(j % 2));
    end
    req = '0;
    tick(); tick(); tick();

    // Wrap-around: core 3 wins, then cores 3 and 1 compete
    do_reset();
    set_core(3, 1'b0, 8'h0D, 16'h0);
    set_core(1, 1'b0, 8'h0D, 16'h0);
    req = 4'b1000;
    tick();
    check("wrap_grant3", 64'(grant_id), 64'(3));
    tick();
    check("wrap_ack3", 64'(ack), 64'(4'b1000));
    req = 4'b1010;
    tick();
    check("wrap_en1", 64'(mem_en), 64'(1));
    check("wrap_grant1", 64'(grant_id), 64'(1));
    req = 4'b0010;
    tick();
    check("wrap_ack1", 64'(ack), 64'(4'b0010));
    check("wrap_rdata", 64'(rdata), 64'(16'h0005));
    tick();
    check("wrap_owner_masked", 64'(busy), 64'(0));
    check("wrap_no_ack", 64'(ack), 64'(0));
    req = '0;
    $display("txn wrap: grants 3 then 1, owner not re-granted");
    tick();

    // Async reset during ISSUE
    do_reset();
    set_core(2, 1'b0, 8'h0D, 16'h0);
    req = 4'b0100;
    tick(); tick();
    req = '0;
    tick();
    set_core(1, 1'b0, 8'h0D, 16'h0);
    set_core(3, 1'b0, 8'h0E, 16'h0);
    req = 4'b0010;
    tick();
    check("arst_pre_en", 64'(mem_en), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_en_now", 64'(mem_en), 64'(0));
    check("arst_busy_now", 64'(busy), 64'(0));
    check("arst_ack_now", 64'(ack), 64'(0));
    req = 4'b1010;
    tick();
    check("arst_ack_held", 64'(ack), 64'(0));
    check("arst_en_held", 64'(mem_en), 64'(0));
    rst = 1'b0;
    tick();
    check("arst_regrant", 64'(grant_id), 64'(1));
    check("arst_en_after", 64'(mem_en), 64'(1));
    req = 4'b0010;
    tick();
    check("arst_ack_after", 64'(ack), 64'(4'b0010));
    req = '0;
    tick();
    $display("txn async reset: core 1 re-arbitrated from pointer 0");

    // Idle stability
    for (int j = 0; j < 20; j++) begin
      check("idle_en", 64'(mem_en), 64'(0));
      check("idle_ack", 64'(ack), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_grant", 64'(grant_id), 64'(1));
      check("idle_rdata", 64'(rdata), 64'(16'h0005));
      tick();
    end
    $display("txn idle: 20 quiet cycles");

    // Random traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    cur.valid = 1'b0; cur.g = 0; cur.core = 0;
    next_arb = 0; last_w = N - 1; rd_exp = '0;
    for (int k = 0; k < N; k++) begin hold_f[k] = 1'b0; drop_f[k] = 1'b0; end
    for (int c = 0; c < N_RAND; c++) begin
      exp_en   = cur.valid && (c == cur.g + 1);
      exp_ackc = cur.valid && (c == cur.g + 2);
      if (exp_ackc && !cur.wr) rd_exp = cur.rd;
      check("rnd_en", 64'(mem_en), 64'(exp_en));
      check("rnd_ack", 64'(ack), exp_ackc ? (64'(1) << cur.core) : 64'(0));
      check("rnd_busy", 64'(busy), 64'(exp_en || exp_ackc));
      check("rnd_rdata", 64'(rdata), 64'(rd_exp));
      if (exp_en) begin
        check("rnd_grant", 64'(grant_id), 64'(cur.core));
        check("rnd_we", 64'(mem_we), 64'(cur.wr));
        check("rnd_maddr", 64'(mem_addr), 64'(cur.a));
        if (cur.wr) check("rnd_mwdata", 64'(mem_wdata), 64'(cur.wd));
      end
      if (exp_ackc)
        $display("txn rand c=%0d core=%0d wr=%0d addr=%02h data=%04h", c, cur.core, cur.wr, cur.a, cur.wr ? cur.wd : cur.rd);

      // Core behaviour for this cycle
      for (int k = 0; k < N; k++) begin
        if (exp_ackc && cur.core == k) begin
          hold_f[k] = 1'b0;
          drop_f[k] = 1'b1;
        end else if (drop_f[k]) begin
          drop_f[k] = 1'b0;
          rand_fields(k);
          req[k] = ($urandom_range(0, 2) == 0);
        end else if (hold_f[k]) begin
          // granted: hold request contents
        end else if (req[k]) begin
          if ($urandom_range(0, 3) == 0) rand_fields(k);
        end else begin
          rand_fields(k);
          req[k] = ($urandom_range(0, 2) == 0);
        end
      end

      // Arbitration opportunity
      if (c >= next_arb) begin
        elig = req;
        if (exp_ackc) elig[cur.core] = 1'b0;
        start = (last_w + 1) % N;
        granted = 1'b0;
        for (int off = 0; off < N; off++) begin
          kk = (start + off) % N;
          if (!granted && elig[kk]) begin
            granted  = 1'b1;
            nw.valid = 1'b1;
            nw.g     = c;
            nw.core  = kk;
            nw.wr    = we[kk];
            nw.a     = addr[kk*AW +: AW];
            nw.wd    = wdata[kk*DW +: DW];
            nw.rd    = ref_mem[nw.a];
            if (nw.wr) ref_mem[nw.a] = nw.wd;
          end
        end
        if (granted) begin
          cur = nw;
          last_w = nw.core;
          next_arb = c + 2;
          hold_f[nw.core] = 1'b1;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port 256x16 main memory between the four waterbear cores of the multicore build.
- Each core issues a memory request (instruction fetch or data load/store), holds it, and waits for a one-cycle ack.
- The arbiter sequences exactly one memory access at a time and returns read data to the winner.
- It sits between the cores' memory interfaces and the shared memory array.

Parameters:
- N_REQ, 4, number of requesting cores (2..8).
- AW, 8, memory address width.
- DW, 16, memory word width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-core request, held high until that core's ack.
- we  input  N_REQ  per-core write enable; sampled with req.
- addr  input  N_REQ*AW  packed addresses; core k uses bits [k*AW +: AW].
- wdata  input  N_REQ*DW  packed write data; core k uses bits [k*DW +: DW].
- ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted core.
- rdata  output  DW  read data broadcast to all cores; valid only with a read ack.
- grant_id  output  3  index of the core currently owning memory.
- busy  output  1  high while state != IDLE.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, any time, including mid-access):
  - State goes to IDLE; ack=0, mem_en=0, mem_we=0, busy=0.
  - grant_id=0, rr_ptr=0, rdata=0, mem_addr=0, mem_wdata=0.
  - An in-flight access is abandoned and no ack is issued.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req bit is set, pick a winner (see Arbitration), latch it into grant_id, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we=we[grant_id], mem_addr/mem_wdata taken from the grant_id slice.
  - Always goes to RESP.
  - The access is committed: dropping req here is a protocol violation, but the ack is still issued.
- RESP (exactly 1 cycle):
  - ack[grant_id]=1.
  - rdata=mem_rdata for reads; rdata is held (unchanged) for writes.
  - rr_ptr becomes (grant_id+1) mod N_REQ.
  - Arbitration runs with req[grant_id] masked, because the current owner still shows req high this cycle.
  - If another request is pending, latch the new winner and go straight to ISSUE (back-to-back); otherwise go to IDLE.
- Arbitration:
  - Rotating priority starting at rr_ptr, wrapping from N_REQ-1 to 0.
  - The first set bit wins.
  - Combinational; evaluated only in IDLE and RESP.
- Latency and throughput:
  - req rising in IDLE at cycle T gives mem_en in T+1 and ack in T+2.
  - Sustained throughput is one access per 2 cycles under contention.
- Fairness: with all N_REQ requesting continuously, each core gets exactly one grant per N_REQ grants.
- Requester rule: after ack the core must drop req, or present a new request, in the following cycle. A req still high at the next arbitration counts as a new request.
- Outputs mem_en, mem_we and ack are decoded from registered state plus grant_id: glitch-free, with no combinational path from req.
- rdata is registered in RESP and remains stable until the next read RESP.
- Requests from cores that are not granted are ignored: their addr, wdata and we may change freely.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and defaults for N_REQ/AW/DW.
- Sub-module mem_arb_rr_pick: combinational rotating-priority picker. Inputs: req vector, mask vector, rr_ptr. Outputs: valid, index.
- The top holds the FSM, grant_id/rr_ptr registers and the memory-side muxes.

Test Plan:
- Single read: after reset, core 2 reads addr 0x0D while memory holds 0x0005 -> mem_en at T+1 with mem_addr=0x0D and mem_we=0; ack=4'b0100 at T+2 with rdata=0x0005; busy low at T+3.
- Write then read: core 0 writes 0x000C to addr 0x0F, then reads it back -> mem_we=1 and mem_wdata=0x000C in ISSUE; the later read returns rdata=0x000C.
- Full contention: all 4 req held high from reset -> grant order 0,1,2,3,0,1; acks spaced 2 cycles apart; no core granted twice within 4 grants.
- Wrap-around: grant to core 3, then only cores 3 and 1 requesting -> next grant goes to 1 (rr_ptr=0, search 0,1); core 3 is not re-granted while still holding req in its RESP cycle.
- Async reset mid-access: assert rst during ISSUE for core 1 -> ack never pulses; mem_en=0 immediately, without waiting for a clock edge; after release, a pending core 1 req is re-arbitrated from rr_ptr=0.
- Idle stability: no req for 20 cycles -> mem_en, ack and busy stay 0; grant_id and rdata unchanged.
